// File: rtl/data_mem_pipe_if.sv
// ----------------------------------------------------------------------------
// data_mem_pipe_if
//   Request/response bundle for the pipelined data memory.
//
//   Handshake rule (both channels): a transfer happens on a rising clock edge
//   where valid && ready are both high. The producer holds valid and its
//   payload stable until that edge; the consumer may raise or lower ready at
//   any time.
//
//   Request channel  (master -> slave): req_valid, req_addr, req_write,
//                                       req_size, req_sign_ext, req_wdata
//                    (slave -> master): req_ready
//   Response channel (slave -> master): rsp_valid, rsp_rdata, rsp_error
//                    (master -> slave): rsp_ready
//   Status           (slave -> master): err_count, saturating error counter
//
//   Modports: master = LSU / MEM stage side, slave = memory side.
// ----------------------------------------------------------------------------
interface data_mem_pipe_if #(
    parameter int ERR_CNT_W = 16
);
    logic                 req_valid;
    logic                 req_ready;
    logic [31:0]          req_addr;
    logic                 req_write;
    logic [1:0]           req_size;
    logic                 req_sign_ext;
    logic [31:0]          req_wdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [31:0]          rsp_rdata;
    logic                 rsp_error;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output req_valid, req_addr, req_write, req_size, req_sign_ext,
               req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error, err_count
    );

    modport slave (
        input  req_valid, req_addr, req_write, req_size, req_sign_ext,
               req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error, err_count
    );
endinterface

// File: rtl/data_mem_pipe.sv
// ----------------------------------------------------------------------------
// data_mem_pipe
//   Byte-addressed, little-endian data memory with a valid/ready request and
//   response handshake and a configurable read latency. Supports byte, half
//   and word loads (signed / unsigned) and stores, and flags illegal accesses.
//
//   Timing: a request accepted at edge N produces its response right after
//   edge N+READ_LATENCY. The access itself (store commit or load sample)
//   happens at the accept edge; the result is captured there and then walks
//   READ_LATENCY further stage registers. When the response is valid but not
//   consumed the whole pipeline freezes and req_ready drops.
//
// Parameters
//   ADDR_WIDTH    byte-address bits decoded, storage = 2**ADDR_WIDTH bytes
//   READ_LATENCY  accept-to-response cycles, 1..3
//   ERR_CNT_W     width of the saturating error counter
//
// Ports
//   clock   in   rising-edge clock
//   reset   in   synchronous, active-high; clears pipeline and err_count,
//                memory contents are kept
//   bus     slave modport of data_mem_pipe_if (request/response channels,
//           err_count)
//
// Build option
//   DMEM_MISALIGN_TRAP_EN  when defined, misaligned half/word accesses return
//                          an error and do not write. When undefined, the low
//                          address bits are ignored (force-aligned access).
// ----------------------------------------------------------------------------
module data_mem_pipe #(
    parameter int ADDR_WIDTH   = 12,
    parameter int READ_LATENCY = 1,
    parameter int ERR_CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    data_mem_pipe_if.slave   bus
);

    generate
        if (READ_LATENCY < 1 || READ_LATENCY > 3) begin : g_bad_latency
            $error("data_mem_pipe: READ_LATENCY must be in 1..3");
        end
        if (ADDR_WIDTH < 3 || ADDR_WIDTH > 31) begin : g_bad_addr_width
            $error("data_mem_pipe: ADDR_WIDTH must be in 3..31");
        end
    endgenerate

    localparam int NWORDS = 2 ** (ADDR_WIDTH - 2);
    // Slot 0 is loaded at the accept edge, slot READ_LATENCY drives the outputs.
    localparam int NSTG   = READ_LATENCY + 1;

    // Storage: one 32-bit word per entry, split into four byte lanes.
    logic [3:0][7:0] r_mem [NWORDS];

    logic [NSTG-1:0]        r_vld;
    logic [NSTG-1:0]        r_err;
    logic [NSTG-1:0][31:0]  r_dat;
    logic [ERR_CNT_W-1:0]   r_err_count;

    logic                   w_stall;
    logic                   w_accept;
    logic                   w_out_of_range;
    logic                   w_bad_size;
    logic                   w_misaligned;
    logic                   w_error;
    logic [1:0]             w_lane;
    logic [ADDR_WIDTH-3:0]  w_word_idx;
    logic [3:0]             w_be;
    logic [3:0][7:0]        w_wlanes;
    logic [3:0][7:0]        w_rd_word;
    logic [7:0]             w_rd_byte;
    logic [15:0]            w_rd_half;
    logic [31:0]            w_load_data;
    logic                   w_rsp_fire;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign w_stall       = r_vld[NSTG-1] && !bus.rsp_ready;
    assign bus.req_ready = !reset && !w_stall;
    assign w_accept      = bus.req_valid && bus.req_ready;
    assign w_rsp_fire    = r_vld[NSTG-1] && bus.rsp_ready;

    // ------------------------------------------------------------------
    // Address decode and legality
    // ------------------------------------------------------------------
    assign w_out_of_range = |bus.req_addr[31:ADDR_WIDTH];
    assign w_bad_size     = (bus.req_size == 2'b11);
    assign w_word_idx     = bus.req_addr[ADDR_WIDTH-1:2];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign w_misaligned = ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
                          ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    // Misaligned accesses are errors, so the raw low bits are the lane.
    assign w_lane       = bus.req_addr[1:0];
`else
    assign w_misaligned = 1'b0;
    // Legacy behaviour: drop the low bits that would make the access misaligned.
    always_comb begin
        w_lane = 2'b00;
        case (bus.req_size)
            2'b00:   w_lane = bus.req_addr[1:0];
            2'b01:   w_lane = {bus.req_addr[1], 1'b0};
            default: w_lane = 2'b00;
        endcase
    end
`endif

    assign w_error = w_out_of_range || w_bad_size || w_misaligned;

    // ------------------------------------------------------------------
    // Store path: replicate the LSB-aligned data to every lane and let the
    // byte enables pick the lanes that are actually written.
    // ------------------------------------------------------------------
    always_comb begin
        w_be     = 4'b0000;
        w_wlanes = '0;
        case (bus.req_size)
            2'b00: begin
                w_be     = 4'b0001 << w_lane;
                w_wlanes = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                w_be     = 4'b0011 << w_lane;
                w_wlanes = {2{bus.req_wdata[15:0]}};
            end
            2'b10: begin
                w_be     = 4'b1111;
                w_wlanes = bus.req_wdata;
            end
            default: begin
                w_be     = 4'b0000;
                w_wlanes = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_accept && bus.req_write && !w_error) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_word_idx][i] <= w_wlanes[i];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Load path: asynchronous read of the addressed word, captured into the
    // pipeline at the accept edge, so a store on the previous edge is seen.
    // ------------------------------------------------------------------
    assign w_rd_word = r_mem[w_word_idx];
    assign w_rd_byte = w_rd_word[w_lane];
    assign w_rd_half = w_lane[1] ? w_rd_word[3:2] : w_rd_word[1:0];

    always_comb begin
        w_load_data = 32'h0;
        if (!bus.req_write && !w_error) begin
            case (bus.req_size)
                2'b00:   w_load_data = {{24{bus.req_sign_ext & w_rd_byte[7]}}, w_rd_byte};
                2'b01:   w_load_data = {{16{bus.req_sign_ext & w_rd_half[15]}}, w_rd_half};
                2'b10:   w_load_data = w_rd_word;
                default: w_load_data = 32'h0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Response pipeline: shifts every cycle unless the output is stalled.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_vld <= '0;
            r_err <= '0;
            r_dat <= '0;
        end else if (!w_stall) begin
            r_vld[0] <= w_accept;
            r_err[0] <= w_accept && w_error;
            r_dat[0] <= w_accept ? w_load_data : 32'h0;
            for (int i = 1; i < NSTG; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_err[i] <= r_err[i-1];
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Error counter: counts errored responses as they are consumed.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_rsp_fire && r_err[NSTG-1] && (r_err_count != '1)) begin
            r_err_count <= r_err_count + ERR_CNT_W'(1);
        end
    end

    assign bus.rsp_valid = r_vld[NSTG-1];
    assign bus.rsp_error = r_err[NSTG-1];
    assign bus.rsp_rdata = r_dat[NSTG-1];
    assign bus.err_count = r_err_count;

endmodule
